// File: rtl/rv32_pkg.sv
// Shared RV32-style definitions: ALU mode encoding, memory-stage FSM states
// and small decode helpers used by the execute and memory stages.
package rv32_pkg;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'd0,
    ALU_ADDI = 6'd1,
    ALU_SUB  = 6'd2,
    ALU_SUBI = 6'd3,
    ALU_MULT = 6'd4,
    ALU_AND  = 6'd5,
    ALU_ANDI = 6'd6,
    ALU_OR   = 6'd7,
    ALU_ORI  = 6'd8,
    ALU_XORI = 6'd9,
    ALU_SLL  = 6'd10,
    ALU_SRL  = 6'd11,
    ALU_SLT  = 6'd12,
    ALU_SLTI = 6'd13,
    ALU_LD   = 6'd14,
    ALU_ST   = 6'd15,
    ALU_BEQ  = 6'd16,
    ALU_BNE  = 6'd17,
    ALU_BLT  = 6'd18,
    ALU_BGE  = 6'd19,
    ALU_JAL  = 6'd20
  } alu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Register-file write enable for a completed instruction; unknown codes never write.
  function automatic logic mode_writes_rd(input logic [5:0] mode);
    logic en;
    en = 1'b0;
    case (mode)
      ALU_ADD, ALU_ADDI, ALU_SUB, ALU_SUBI, ALU_MULT,
      ALU_AND, ALU_ANDI, ALU_OR, ALU_ORI, ALU_XORI,
      ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTI, ALU_LD: en = 1'b1;
      default: en = 1'b0;
    endcase
    return en;
  endfunction

  function automatic logic mode_is_mem(input logic [5:0] mode);
    return (mode == ALU_LD) || (mode == ALU_ST);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the memory stage's execute-side, data-memory and writeback signals.
// slave = the stage itself, master = upstream pipeline plus data memory.
interface mem_stage_if;
  logic        valid;
  logic [5:0]  alu_mode;
  logic [31:0] alu_out;
  logic [31:0] b;
  logic [4:0]  rd;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        misalign;

  modport slave (
    input  valid, alu_mode, alu_out, b, rd, mem_ack, mem_rdata,
    output stall, mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_en, wb_data, wb_rd, misalign
  );

  modport master (
    output valid, alu_mode, alu_out, b, rd, mem_ack, mem_rdata,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_en, wb_data, wb_rd, misalign
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results to writeback, runs LD/ST over a req/ack bus.
// Optional `MISALIGN_CHECK_EN traps LD/ST with addr[1:0]!=0 instead of truncating.
module mem_stage
  import rv32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [5:0]  i_ALUmode,
  input  logic [31:0] i_ALUOutput,
  input  logic [31:0] i_B,
  input  logic [4:0]  i_rd,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_valid,
  output logic        o_wb_en,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_rd,
  output logic        o_misalign
);

  mem_state_e  state_q;
  logic        valid_q;
  logic        wb_en_q;
  logic        misalign_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        is_ld_q;
  logic [31:0] wb_data_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [4:0]  rd_q;

  logic is_mem;
  logic misaligned;

  assign is_mem = mode_is_mem(i_ALUmode);

`ifdef MISALIGN_CHECK_EN
  assign misaligned = |i_ALUOutput[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      wb_en_q     <= 1'b0;
      misalign_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      is_ld_q     <= 1'b0;
      wb_data_q   <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rd_q        <= 5'd0;
    end else begin
      // Writeback and fault indications are single-cycle pulses.
      valid_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            if (is_mem && misaligned) begin
              misalign_q <= 1'b1;
            end else if (is_mem) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= (i_ALUmode == ALU_ST);
              is_ld_q     <= (i_ALUmode == ALU_LD);
              mem_addr_q  <= {i_ALUOutput[31:2], 2'b00};
              mem_wdata_q <= i_B;
              rd_q        <= i_rd;
              state_q     <= ST_BUSY;
            end else begin
              valid_q   <= 1'b1;
              wb_en_q   <= mode_writes_rd(i_ALUmode);
              wb_data_q <= i_ALUOutput;
              rd_q      <= i_rd;
            end
          end
        end
        ST_BUSY: begin
          // Request and payload hold until the memory acknowledges.
          if (i_mem_ack) begin
            mem_req_q <= 1'b0;
            valid_q   <= 1'b1;
            wb_en_q   <= is_ld_q;
            wb_data_q <= is_ld_q ? i_mem_rdata : 32'd0;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_stall     = (state_q != ST_IDLE);
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_valid     = valid_q;
  assign o_wb_en     = wb_en_q;
  assign o_wb_data   = wb_data_q;
  assign o_rd        = rd_q;
  assign o_misalign  = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a writeback scoreboard.
// Build with +define+MISALIGN_CHECK_EN to exercise the misalignment trap.
module tb_mem_stage;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_valid     (bus.valid),
    .i_ALUmode   (bus.alu_mode),
    .i_ALUOutput (bus.alu_out),
    .i_B         (bus.b),
    .i_rd        (bus.rd),
    .o_stall     (bus.stall),
    .o_mem_req   (bus.mem_req),
    .o_mem_we    (bus.mem_we),
    .o_mem_addr  (bus.mem_addr),
    .o_mem_wdata (bus.mem_wdata),
    .i_mem_ack   (bus.mem_ack),
    .i_mem_rdata (bus.mem_rdata),
    .o_valid     (bus.wb_valid),
    .o_wb_en     (bus.wb_en),
    .o_wb_data   (bus.wb_data),
    .o_rd        (bus.wb_rd),
    .o_misalign  (bus.misalign)
  );

  typedef struct packed {
    logic        en;
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  wb_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one execute-stage result; the expected writeback record goes to the scoreboard.
  task automatic issue(input logic [5:0] mode, input logic [31:0] res, input logic [31:0] b,
                       input logic [4:0] rd, input logic push, input wb_t exp);
    bus.valid    = 1'b1;
    bus.alu_mode = mode;
    bus.alu_out  = res;
    bus.b        = b;
    bus.rd       = rd;
    if (push) sb.push_back(exp);
  endtask

  task automatic expect_wb(input string tag);
    wb_t e;
    chk({tag, "_valid"}, {31'd0, bus.wb_valid}, 32'd1);
    chk({tag, "_req_low"}, {31'd0, bus.mem_req}, 32'd0);
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_wb_en"}, {31'd0, bus.wb_en}, {31'd0, e.en});
      chk({tag, "_wb_data"}, bus.wb_data, e.data);
      chk({tag, "_rd"}, {27'd0, bus.wb_rd}, {27'd0, e.rd});
    end
    $display("txn %s: wb_en=%0d wb_data=0x%08h rd=%0d", tag, bus.wb_en, bus.wb_data, bus.wb_rd);
  endtask

  // valid / misalign / mem_req are mutually exclusive every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert ((int'(bus.wb_valid) + int'(bus.misalign) + int'(bus.mem_req)) <= 1) else begin
        failures++;
        $error("FAIL exclusive observed=%0d%0d%0d expected=at_most_one",
               bus.wb_valid, bus.misalign, bus.mem_req);
      end
    end
  end

  logic [5:0] modes [8];
  logic       ens   [8];

  initial begin
    bus.valid     = 1'b0;
    bus.alu_mode  = 6'd0;
    bus.alu_out   = 32'd0;
    bus.b         = 32'd0;
    bus.rd        = 5'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    modes = '{ALU_ADD, ALU_SUB, ALU_MULT, ALU_SLT, ALU_ORI, ALU_BNE, ALU_JAL, 6'h3F};
    ens   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state.
    rst = 1'b1;
    step();
    step();
    chk("rst_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_misalign", {31'd0, bus.misalign}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    rst = 1'b0;

    // ADD with 1-cycle latency.
    issue(ALU_ADD, 32'h10, 32'h0, 5'd5, 1'b1, '{en: 1'b1, data: 32'h10, rd: 5'd5});
    step();
    bus.valid = 1'b0;
    expect_wb("add");
    chk("add_stall", {31'd0, bus.stall}, 32'd0);
    step();
    chk("add_pulse", {31'd0, bus.wb_valid}, 32'd0);

    // Back-to-back non-memory ops, including an unknown code.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] r;
      r = $urandom;
      issue(modes[i], r, 32'h0, 5'(i + 10), 1'b1, '{en: ens[i], data: r, rd: 5'(i + 10)});
      step();
      expect_wb($sformatf("op%0d", i));
    end
    bus.valid = 1'b0;
    step();

    // LD at 0x100 acked after 3 request cycles; inputs during stall are ignored.
    issue(ALU_LD, 32'h100, 32'hAAAA_0000, 5'd7, 1'b1, '{en: 1'b1, data: 32'hDEAD_BEEF, rd: 5'd7});
    step();
    issue(ALU_ADD, 32'hBAD0_0BAD, 32'h0, 5'd1, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ld_req%0d", c), {31'd0, bus.mem_req}, 32'd1);
      chk($sformatf("ld_we%0d", c), {31'd0, bus.mem_we}, 32'd0);
      chk($sformatf("ld_addr%0d", c), bus.mem_addr, 32'h100);
      chk($sformatf("ld_stall%0d", c), {31'd0, bus.stall}, 32'd1);
      chk($sformatf("ld_novalid%0d", c), {31'd0, bus.wb_valid}, 32'd0);
      if (c == 2) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
      step();
    end
    bus.mem_ack = 1'b0;
    bus.valid   = 1'b0;
    expect_wb("ld");
    chk("ld_done_stall", {31'd0, bus.stall}, 32'd1);
    step();
    chk("ld_after_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("ld_after_stall", {31'd0, bus.stall}, 32'd0);

    // ST at 0x204 acked in the first BUSY cycle.
    issue(ALU_ST, 32'h204, 32'h1234_5678, 5'd3, 1'b1, '{en: 1'b0, data: 32'h0, rd: 5'd3});
    step();
    bus.valid = 1'b0;
    chk("st_req", {31'd0, bus.mem_req}, 32'd1);
    chk("st_we", {31'd0, bus.mem_we}, 32'd1);
    chk("st_addr", bus.mem_addr, 32'h204);
    chk("st_wdata", bus.mem_wdata, 32'h1234_5678);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    expect_wb("st");
    step();

    // Reset during BUSY aborts silently; the late ack is ignored.
    issue(ALU_LD, 32'h300, 32'h0, 5'd9, 1'b0, '0);
    step();
    bus.valid = 1'b0;
    step();
    chk("abort_req_busy", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_req", {31'd0, bus.mem_req}, 32'd0);
    chk("abort_stall", {31'd0, bus.stall}, 32'd0);
    chk("abort_wb_data", bus.wb_data, 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    step();
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("abort_novalid%0d", c), {31'd0, bus.wb_valid}, 32'd0);
      chk($sformatf("abort_idle%0d", c), {31'd0, bus.stall}, 32'd0);
      step();
    end

    // BEQ writes nothing; a spurious ack in IDLE changes no output.
    issue(ALU_BEQ, 32'h55, 32'h0, 5'd2, 1'b1, '{en: 1'b0, data: 32'h55, rd: 5'd2});
    step();
    bus.valid = 1'b0;
    expect_wb("beq");
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    bus.mem_ack = 1'b0;
    chk("spur_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("spur_req", {31'd0, bus.mem_req}, 32'd0);
    chk("spur_stall", {31'd0, bus.stall}, 32'd0);
    chk("spur_wb_data", bus.wb_data, 32'h55);
    step();
    chk("spur_req2", {31'd0, bus.mem_req}, 32'd0);

    // Misaligned LD at 0x102.
`ifdef MISALIGN_CHECK_EN
    issue(ALU_LD, 32'h102, 32'h0, 5'd4, 1'b0, '0);
    step();
    bus.valid = 1'b0;
    chk("mis_pulse", {31'd0, bus.misalign}, 32'd1);
    chk("mis_req", {31'd0, bus.mem_req}, 32'd0);
    chk("mis_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("mis_wb_en", {31'd0, bus.wb_en}, 32'd0);
    chk("mis_stall", {31'd0, bus.stall}, 32'd0);
    step();
    chk("mis_pulse_end", {31'd0, bus.misalign}, 32'd0);
    chk("mis_req_end", {31'd0, bus.mem_req}, 32'd0);
    $display("txn misaligned_ld: trapped");
`else
    issue(ALU_LD, 32'h102, 32'h0, 5'd4, 1'b1, '{en: 1'b1, data: 32'hCAFE_F00D, rd: 5'd4});
    step();
    bus.valid = 1'b0;
    chk("mis_req", {31'd0, bus.mem_req}, 32'd1);
    chk("mis_addr", bus.mem_addr, 32'h100);
    chk("mis_flag", {31'd0, bus.misalign}, 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_ack = 1'b0;
    expect_wb("unaligned_ld");
    step();
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; all state changes occur on the rising edge of i_clk.
REQ-002 SHALL expose ports, clock and reset first:
 i_clk  in  1  clock
 i_reset  in  1  synchronous active-high reset
 i_valid  in  1  execute-stage result valid this cycle
 i_ALUmode  in  6  operation code, shared ALU mode encoding
 i_ALUOutput  in  32  execute result / effective address
 i_B  in  32  store data
 i_rd  in  5  destination register index
 o_stall  out  1  upstream must hold its outputs
 o_mem_req  out  1  data-memory request
 o_mem_we  out  1  1 = write
 o_mem_addr  out  32  word address
 o_mem_wdata  out  32  write data
 i_mem_ack  in  1  memory completes request
 i_mem_rdata  in  32  load data, valid with ack
 o_valid  out  1  writeback record valid (1-cycle pulse)
 o_wb_en  out  1  register write enable
 o_wb_data  out  32  writeback value
 o_rd  out  5  writeback register index
 o_misalign  out  1  misaligned-access fault pulse

Function
REQ-003 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-004 IDLE, i_valid=1, non-memory mode: in the next cycle, o_valid=1, o_wb_data=i_ALUOutput, o_rd=i_rd; FSM stays IDLE; latency 1 cycle.
REQ-005 o_wb_en SHALL be 1 for ADD/ADDI/SUB/SUBI/MULT/AND/ANDI/OR/ORI/XORI/SLL/SRL/SLT/SLTI/LD, and 0 for ST/BEQ/BNE/BLT/BGE/JAL and for unknown codes.
REQ-006 IDLE, i_valid=1, LD or ST: latch address, data, rd and mode; go to BUSY; assert o_mem_req from the next cycle with o_mem_we=(ST), o_mem_addr={addr[31:2],2'b00}, o_mem_wdata=i_B.
REQ-007 BUSY: o_mem_req and its payload SHALL stay stable until i_mem_ack=1; ack is legal in the first BUSY cycle.
REQ-008 Ack in BUSY: drop o_mem_req next cycle; go to DONE; capture i_mem_rdata for LD.
REQ-009 DONE: o_valid=1 for one cycle, o_wb_data = captured rdata (LD) or 0 (ST); return to IDLE.
REQ-010 o_stall SHALL be combinationally high in BUSY and DONE; i_valid and all payload inputs are ignored while o_stall=1.
REQ-011 i_mem_ack outside BUSY SHALL be ignored.
REQ-012 o_valid, o_misalign and o_mem_req SHALL never be asserted in the same cycle.

Reset
REQ-013 Reset SHALL force FSM=IDLE and o_mem_req=0, o_mem_we=0, o_valid=0, o_wb_en=0, o_misalign=0, o_stall=0, o_wb_data=0, o_rd=0, o_mem_addr=0, o_mem_wdata=0.
REQ-014 Reset during BUSY SHALL abort the transaction silently: no o_valid, and a late ack is ignored per REQ-011.

Configuration
REQ-015 Macro MISALIGN_CHECK_EN defined: an LD/ST with addr[1:0]!=0 issues no request and stays IDLE; the next cycle gives o_misalign=1 for one cycle with o_wb_en=0 and o_valid=0.
REQ-016 Macro MISALIGN_CHECK_EN undefined: addr[1:0] is silently dropped per REQ-006, and o_misalign is tied to 0 (the port remains present).

Structure
REQ-017 The ALU mode enumeration (6-bit) and the FSM state typedef SHALL live in a shared package, rv32_pkg, imported by the ALU and mem_stage.
REQ-018 No sub-module is needed; a single module of about 150-250 lines.

Verification
REQ-019 ADD, i_valid=1, i_ALUOutput=0x0000_0010, i_rd=5 -> next cycle: o_valid=1, o_wb_en=1, o_wb_data=0x10, o_rd=5, o_mem_req=0.
REQ-020 LD, addr=0x100, ack 3 cycles after req with rdata=0xDEAD_BEEF -> req held 3 cycles at addr 0x100, we=0; o_valid one cycle after ack with o_wb_data=0xDEADBEEF; o_stall high throughout.
REQ-021 ST, addr=0x204, i_B=0x1234_5678, ack in the first BUSY cycle -> one-cycle req with we=1, wdata=0x12345678; then o_valid=1, o_wb_en=0.
REQ-022 LD issued, i_reset pulsed in the second BUSY cycle, ack arrives afterwards -> req=0 after reset, no o_valid, FSM in IDLE.
REQ-023 BEQ with i_valid=1 -> o_valid=1, o_wb_en=0; and a spurious ack in IDLE -> no output change.
REQ-024 MISALIGN_CHECK_EN defined, LD at addr 0x102 -> no req, o_misalign=1 for one cycle; macro undefined -> req at 0x100.
